// File: rtl/mem_arbiter_pkg.sv
// Shared state encodings and constants for the IF/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle   = 2'd0,
        ArbIfBusy = 2'd1,
        ArbDmBusy = 2'd2
    } arb_state_e;

    // Read data handed back on an aborted access; sliced down to DATA_WIDTH.
    localparam logic [63:0] ArbAbortRdata = 64'h0;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side (IF, data) and memory-side signals of the arbiter in one bundle.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_ack;
    logic                  if_stall;
    logic                  dm_ren;
    logic                  dm_wen;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_ack;
    logic                  dm_stall;
    logic                  mem_cs;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic                  mem_ack;
    logic                  timeout_err;

    // The arbiter masters the memory bus and serves both pipeline ports.
    modport master (
        input  if_req, if_addr, dm_ren, dm_wen, dm_addr, dm_wdata, mem_dout, mem_ack,
        output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
               mem_cs, mem_we, mem_addr, mem_din, timeout_err
    );

    modport slave (
        output if_req, if_addr, dm_ren, dm_wen, dm_addr, dm_wdata, mem_dout, mem_ack,
        input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
               mem_cs, mem_we, mem_addr, mem_din, timeout_err
    );

endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Busy-cycle watchdog for the memory arbiter; only used when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic busy_i,
    input  logic ack_i,
    output logic expire_o,
    output logic err_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    // Expire in the busy cycle whose increment would reach TIMEOUT; a real ack wins.
    assign expire_o = busy_i & ~ack_i & (({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT));
    assign err_o    = err_q;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | expire_o;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (busy_i && !ack_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Define MEM_ARB_TIMEOUT_EN to abort accesses the memory never acknowledges.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    arb_state_e            state_q, state_d;
    logic                  last_dm_q, last_dm_d;
    logic                  mem_cs_q, mem_cs_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  if_ack_q, if_ack_d;
    logic                  dm_ack_q, dm_ack_d;
    logic                  dm_req, if_pend, dm_pend, grant_dm, grant_if;
    logic                  wd_expire;
    logic [DATA_WIDTH-1:0] rdata_in;

    assign dm_req  = bus.dm_ren | bus.dm_wen;
    // A port whose ack is showing still holds its request this cycle; don't re-grant it.
    assign if_pend = bus.if_req & ~if_ack_q;
    assign dm_pend = dm_req & ~dm_ack_q;

    assign grant_dm = (state_q == ArbIdle) & dm_pend & (~if_pend | ~last_dm_q);
    assign grant_if = (state_q == ArbIdle) & if_pend & ~grant_dm;

    assign rdata_in = bus.mem_ack ? bus.mem_dout : ArbAbortRdata[DATA_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        last_dm_d  = last_dm_q;
        mem_cs_d   = mem_cs_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        unique case (state_q)
            ArbIdle: begin
                if (grant_dm || grant_if) begin
                    mem_cs_d   = 1'b1;
                    mem_we_d   = grant_dm & bus.dm_wen;
                    mem_addr_d = grant_dm ? bus.dm_addr : bus.if_addr;
                    mem_din_d  = bus.dm_wdata;
                    state_d    = grant_dm ? ArbDmBusy : ArbIfBusy;
                end
            end
            ArbIfBusy: begin
                if (bus.mem_ack || wd_expire) begin
                    if_rdata_d = rdata_in;
                    if_ack_d   = 1'b1;
                    last_dm_d  = 1'b0;
                    mem_cs_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    state_d    = ArbIdle;
                end
            end
            ArbDmBusy: begin
                if (bus.mem_ack || wd_expire) begin
                    if (!mem_we_q) begin
                        dm_rdata_d = rdata_in;
                    end
                    dm_ack_d  = 1'b1;
                    last_dm_d = 1'b1;
                    mem_cs_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ArbIdle;
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ArbIdle;
            last_dm_q  <= 1'b0;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dm_q  <= last_dm_d;
            mem_cs_q   <= mem_cs_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic wd_err;

    mem_arbiter_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear_i (grant_dm | grant_if),
        .busy_i  (state_q != ArbIdle),
        .ack_i   (bus.mem_ack),
        .expire_o(wd_expire),
        .err_o   (wd_err)
    );

    assign bus.timeout_err = wd_err;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout  = TIMEOUT;
    assign wd_expire       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.mem_cs   = mem_cs_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.dm_rdata = dm_rdata_q;
    assign bus.if_ack   = if_ack_q;
    assign bus.dm_ack   = dm_ack_q;
    assign bus.if_stall = bus.if_req & ~if_ack_q;
    assign bus.dm_stall = dm_req & ~dm_ack_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch (IF) port and the data (MEM-stage lw/sw) port of the 5-stage MIPS pipeline.
- The memory has variable latency and completes each access with a req/ack handshake.
- The block sequences one transaction at a time and holds the memory bus stable until the memory acks.
- It returns read data, pulses a per-port ack and drives per-port stall signals to the pipeline controller.

Parameters:
ADDR_WIDTH, 32, address width of both ports and the memory bus
DATA_WIDTH, 32, data width
TIMEOUT, 255, cycles to wait for mem_ack before abort (only used with the optional feature)

Ports:
clk  in  1  main clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  instruction read request, held until if_ack
if_addr  in  ADDR_WIDTH  instruction address
if_rdata  out  DATA_WIDTH  fetched instruction, valid when if_ack=1
if_ack  out  1  one-cycle completion pulse for the IF port
if_stall  out  1  IF request pending and not yet acked
dm_ren  in  1  data read request
dm_wen  in  1  data write request
dm_addr  in  ADDR_WIDTH  data address
dm_wdata  in  DATA_WIDTH  store data
dm_rdata  out  DATA_WIDTH  load data, valid when dm_ack=1
dm_ack  out  1  one-cycle completion pulse for the data port
dm_stall  out  1  data request pending and not yet acked
mem_cs  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_din  out  DATA_WIDTH  memory write data
mem_dout  in  DATA_WIDTH  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, single cycle
timeout_err  out  1  sticky abort flag; constant 0 when the optional feature is absent

Behaviour:
- FSM states: IDLE, IF_BUSY, DM_BUSY.
- Flag last_dm (1 bit): set when a DM transaction completes, cleared when an IF transaction completes.
- Reset (async): state=IDLE, last_dm=0, all outputs 0 (mem_cs, mem_we, mem_addr, mem_din, if_rdata, dm_rdata, if_ack, dm_ack, timeout_err).
  - Reset mid-transaction drops mem_cs immediately; the in-flight access is abandoned.
- IDLE grant rule:
  - A data request is dm_ren|dm_wen.
  - Both pending: the data port wins unless last_dm=1, in which case IF wins (anti-starvation alternation).
  - Only one pending: grant it.
  - None pending: stay in IDLE.
- Grant cycle: register mem_cs=1, mem_addr, mem_we (1 only for dm_wen) and mem_din=dm_wdata.
  - These are registered, so they appear on the bus the cycle after the request is sampled.
  - They stay constant until mem_ack.
- dm_ren and dm_wen both high: treated as a write.
- BUSY states: on mem_ack:
  - Register mem_dout into if_rdata or dm_rdata; writes leave dm_rdata unchanged.
  - Pulse the matching ack for exactly 1 cycle.
  - Drop mem_cs and return to IDLE.
- Latency: minimum 3 cycles from request to ack when the memory acks on the first bus cycle. The IDLE turnaround cycle between back-to-back transactions is mandatory.
- if_stall = if_req & ~if_ack; dm_stall = (dm_ren|dm_wen) & ~dm_ack. Both are combinational from registered acks.
- Requesters hold their request and operands stable until ack and may change them in the cycle after ack. A request deasserted before ack is ignored; a transaction already on the bus still completes.
- mem_ack while in IDLE is ignored.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- Defined:
  - An 8-bit counter clears on grant and increments each BUSY cycle without mem_ack.
  - When the counter reaches TIMEOUT: drop mem_cs, pulse the granted port's ack with rdata=0, set timeout_err (sticky until rst), return to IDLE.
  - mem_ack and the timeout in the same cycle: mem_ack wins.
- Undefined: no counter; BUSY waits indefinitely; timeout_err tied 0.

Decomposition:
- Shared header (mips_define.vh style) holds:
  - state encodings ARB_IDLE/ARB_IF_BUSY/ARB_DM_BUSY (2-bit)
  - the abort read-data constant
- One sub-module is natural: arb_watchdog (counter, TIMEOUT compare, sticky error), instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- IF only: if_req=1, if_addr=0x40, memory acks on the 2nd bus cycle with 0x2008000A -> mem_cs high for 2 cycles, if_ack pulses once, if_rdata=0x2008000A, if_stall low the same cycle.
- Simultaneous IF and data (after reset): dm_ren=1 at 0x100, if_req=1 -> DM served first; IDLE cycle; IF served next (last_dm alternation); dm_rdata=mem_dout; exactly one ack per port.
- Store: dm_wen=1, addr 0x200, wdata 0xCAFEF00D -> mem_we=1, mem_din=0xCAFEF00D held until mem_ack; dm_rdata unchanged.
- Reset mid-transaction: assert rst in DM_BUSY -> mem_cs=0 asynchronously; after release state=IDLE and no stale ack.
- Spurious mem_ack in IDLE -> no ack pulse, no state change.
- MEM_ARB_TIMEOUT_EN, TIMEOUT=4, memory never acks -> abort on the 4th BUSY cycle: ack pulse, rdata=0, timeout_err=1 and held until rst.
